cdc_tx_scheduler: RTL

CDC_TX_SCHEDULER -- requirements
Module: cdc_tx_scheduler

---
 rtl/cdc_sched_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/cdc_tx_scheduler.sv | 81 ++++++++
 3 files changed

// File: rtl/cdc_sched_pkg.sv
// Shared types and defaults for the fast-domain TX scheduler feeding the fast-to-slow data bridge.
package cdc_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, HOLDOFF = 2'd2} sched_state_t;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_HOLD_CYCLES = 32;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the search starts one past the last granted channel.
module rr_arbiter
  import cdc_sched_pkg::*;
#(
  parameter  int NUM_CH = 2,
  localparam int CW     = idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CW-1:0]     last,
  output logic [NUM_CH-1:0] gnt,
  output logic [CW-1:0]     gnt_idx,
  output logic              any
);
  int cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    cand    = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = (int'(last) + k) % NUM_CH;
      if (!any && req[CW'(cand)]) begin
        any              = 1'b1;
        gnt[CW'(cand)]   = 1'b1;
        gnt_idx          = CW'(cand);
      end
    end
  end
endmodule

// File: rtl/cdc_tx_scheduler.sv
// Picks one DSP channel at a time and issues its sample as a single Tx_Valid pulse,
// then holds off long enough for the slow-side bridge to absorb it.
module cdc_tx_scheduler
  import cdc_sched_pkg::*;
#(
  parameter  int WIDTH       = DEF_WIDTH,
  parameter  int NUM_CH      = 2,
  parameter  int HOLD_CYCLES = DEF_HOLD_CYCLES,
  localparam int CW          = idx_w(NUM_CH),
  localparam int HCW         = idx_w(HOLD_CYCLES)
) (
  input  logic                    Clk,
  input  logic                    Rst_N,
  input  logic                    Enable,
  input  logic [NUM_CH-1:0]       Req_Valid,
  input  logic [NUM_CH*WIDTH-1:0] Req_Data,
  output logic [NUM_CH-1:0]       Req_Ready,
  output logic [WIDTH-1:0]        Tx_Data,
  output logic [CW-1:0]           Tx_Chan,
  output logic                    Tx_Valid,
  output logic                    Busy
);
  sched_state_t      state;
  logic [HCW-1:0]    hold_cnt;
  logic [CW-1:0]     last_grant;
  logic [NUM_CH-1:0] arb_gnt;
  logic [CW-1:0]     arb_idx;
  logic              arb_any;
  logic              grant_ok;
  logic              handshake;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req     (Req_Valid),
    .last    (last_grant),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  // Ready is gated by reset too, so nothing is offered while the block is held in reset.
  assign grant_ok  = Rst_N && Enable && (state == IDLE);
  assign Req_Ready = grant_ok ? arb_gnt : '0;
  assign handshake = grant_ok && arb_any;
  assign Busy      = (state != IDLE);

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state      <= IDLE;
      Tx_Valid   <= 1'b0;
      Tx_Data    <= '0;
      Tx_Chan    <= '0;
      hold_cnt   <= '0;
      last_grant <= CW'(NUM_CH - 1);
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            Tx_Data    <= Req_Data[arb_idx*WIDTH +: WIDTH];
            Tx_Chan    <= arb_idx;
            last_grant <= arb_idx;
            Tx_Valid   <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          Tx_Valid <= 1'b0;
          hold_cnt <= HCW'(HOLD_CYCLES - 1);
          state    <= HOLDOFF;
        end
        HOLDOFF: begin
          if (hold_cnt == '0) state <= IDLE;
          else                hold_cnt <= hold_cnt - 1'b1;
        end
        default: begin
          Tx_Valid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule
